// File: rtl/simon_sequence_ctrl.sv
// Simon game sequencer: grows an LFSR-driven colour sequence, plays it back on
// play_tick, and feeds each player press plus the expected colour to the comparator.
module simon_sequence_ctrl #(
  parameter int          MAX_LEN = 16,
  parameter int          LEN_W   = 5,
  parameter logic [7:0]  SEED    = 8'hA5
) (
  input  logic             i_clk,
  input  logic             i_resetn,
  input  logic             i_start,
  input  logic             i_play_tick,
  input  logic             i_btn_valid,
  input  logic [1:0]       i_btn_colour,
  input  logic [1:0]       i_cmp_result,
  output logic [1:0]       o_player_colour,
  output logic [1:0]       o_expected,
  output logic             o_cmp_enable,
  output logic             o_show_valid,
  output logic [1:0]       o_show_colour,
  output logic             o_awaiting_input,
  output logic [LEN_W-1:0] o_round,
  output logic             o_game_over,
  output logic             o_win
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_APPEND, S_PLAY, S_WAIT_IN, S_ISSUE, S_CHECK, S_LOSE, S_WIN
  } state_t;

  state_t           r_state, w_state_next;
  logic [7:0]       r_lfsr;
  logic [LEN_W-1:0] r_round, w_round_next;
  logic [LEN_W-1:0] r_play_idx, w_play_idx_next;
  logic [LEN_W-1:0] r_in_idx, w_in_idx_next;
  logic [1:0]       r_player_colour, w_player_colour_next;
  logic [1:0]       r_expected, w_expected_next;
  logic [1:0]       r_show_colour, w_show_colour_next;
  logic             r_show_valid, w_show_valid_next;
  logic             r_cmp_enable, w_cmp_enable_next;
  logic             r_awaiting, w_awaiting_next;
  logic             r_game_over, w_game_over_next;
  logic             r_win, w_win_next;
  logic             w_mem_we;
  logic             w_lfsr_fb;
  logic [1:0]       r_mem [MAX_LEN];

  // x^8+x^6+x^5+x^4+1
  assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  always_comb begin
    w_state_next         = r_state;
    w_round_next         = r_round;
    w_play_idx_next      = r_play_idx;
    w_in_idx_next        = r_in_idx;
    w_player_colour_next = r_player_colour;
    w_expected_next      = r_expected;
    w_show_colour_next   = r_show_colour;
    w_show_valid_next    = 1'b0;
    w_game_over_next     = r_game_over;
    w_win_next           = r_win;
    w_mem_we             = 1'b0;

    if (i_start) begin
      w_state_next     = S_APPEND;
      w_round_next     = '0;
      w_play_idx_next  = '0;
      w_in_idx_next    = '0;
      w_game_over_next = 1'b0;
      w_win_next       = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: ;
        S_APPEND: begin
          w_mem_we        = 1'b1;
          w_round_next    = r_round + LEN_W'(1);
          w_play_idx_next = '0;
          w_state_next    = S_PLAY;
        end
        S_PLAY: begin
          if (i_play_tick) begin
            w_show_colour_next = r_mem[r_play_idx[IDX_W-1:0]];
            w_show_valid_next  = 1'b1;
            if (r_play_idx == r_round - LEN_W'(1)) begin
              w_in_idx_next = '0;
              w_state_next  = S_WAIT_IN;
            end else begin
              w_play_idx_next = r_play_idx + LEN_W'(1);
            end
          end
        end
        S_WAIT_IN: begin
          if (i_btn_valid) begin
            w_player_colour_next = i_btn_colour;
            w_expected_next      = r_mem[r_in_idx[IDX_W-1:0]];
            w_state_next         = S_ISSUE;
          end
        end
        S_ISSUE: w_state_next = S_CHECK;
        S_CHECK: begin
          // A 00 verdict means the comparator has nothing yet; stay put.
          case (i_cmp_result)
            2'b01: begin
              if (r_in_idx != r_round - LEN_W'(1)) begin
                w_in_idx_next = r_in_idx + LEN_W'(1);
                w_state_next  = S_WAIT_IN;
              end else if (r_round == LEN_W'(MAX_LEN)) begin
                w_win_next   = 1'b1;
                w_state_next = S_WIN;
              end else begin
                w_state_next = S_APPEND;
              end
            end
            2'b10: begin
              w_game_over_next = 1'b1;
              w_state_next     = S_LOSE;
            end
            default: ;
          endcase
        end
        S_LOSE: ;
        S_WIN: ;
        default: w_state_next = S_IDLE;
      endcase
    end

    w_cmp_enable_next = (w_state_next == S_ISSUE);
    w_awaiting_next   = (w_state_next == S_WAIT_IN);
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state         <= S_IDLE;
      r_lfsr          <= SEED;
      r_round         <= '0;
      r_play_idx      <= '0;
      r_in_idx        <= '0;
      r_player_colour <= '0;
      r_expected      <= '0;
      r_show_colour   <= '0;
      r_show_valid    <= 1'b0;
      r_cmp_enable    <= 1'b0;
      r_awaiting      <= 1'b0;
      r_game_over     <= 1'b0;
      r_win           <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_lfsr          <= {r_lfsr[6:0], w_lfsr_fb};
      r_round         <= w_round_next;
      r_play_idx      <= w_play_idx_next;
      r_in_idx        <= w_in_idx_next;
      r_player_colour <= w_player_colour_next;
      r_expected      <= w_expected_next;
      r_show_colour   <= w_show_colour_next;
      r_show_valid    <= w_show_valid_next;
      r_cmp_enable    <= w_cmp_enable_next;
      r_awaiting      <= w_awaiting_next;
      r_game_over     <= w_game_over_next;
      r_win           <= w_win_next;
    end
  end

  // Sequence memory survives reset so it can map onto plain RAM.
  always_ff @(posedge i_clk) begin
    if (w_mem_we) r_mem[r_round[IDX_W-1:0]] <= r_lfsr[1:0];
  end

  assign o_player_colour  = r_player_colour;
  assign o_expected       = r_expected;
  assign o_cmp_enable     = r_cmp_enable;
  assign o_show_valid     = r_show_valid;
  assign o_show_colour    = r_show_colour;
  assign o_awaiting_input = r_awaiting;
  assign o_round          = r_round;
  assign o_game_over      = r_game_over;
  assign o_win            = r_win;

endmodule

// File: tb/tb_simon_sequence_ctrl.sv
// Randomized directed bench for simon_sequence_ctrl; a queue-based game model
// supplies every expected colour, round count and flag.
module tb_simon_sequence_ctrl;

  localparam int         MAX_LEN = 4;
  localparam int         LEN_W   = 5;
  localparam logic [7:0] SEED    = 8'hA5;

  logic             clk = 1'b0;
  logic             resetn;
  logic             start = 1'b0, play_tick = 1'b0, btn_valid = 1'b0;
  logic [1:0]       btn_colour = 2'b00, cmp_result = 2'b00;
  logic [1:0]       player_colour, expected, show_colour;
  logic             cmp_enable, show_valid, awaiting;
  logic [LEN_W-1:0] round;
  logic             game_over, win;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc;
  logic [1:0] model_seq[$];

  simon_sequence_ctrl #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .SEED(SEED)) dut (
    .i_clk(clk), .i_resetn(resetn), .i_start(start), .i_play_tick(play_tick),
    .i_btn_valid(btn_valid), .i_btn_colour(btn_colour), .i_cmp_result(cmp_result),
    .o_player_colour(player_colour), .o_expected(expected), .o_cmp_enable(cmp_enable),
    .o_show_valid(show_valid), .o_show_colour(show_colour), .o_awaiting_input(awaiting),
    .o_round(round), .o_game_over(game_over), .o_win(win)
  );

  always #5 clk = ~clk;

  // Number of clock edges seen since reset released: the LFSR has stepped this many times.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  function automatic logic [7:0] lfsr_after(input int n);
    logic [7:0] l = SEED;
    for (int k = 0; k < n; k++) l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    return l;
  endfunction

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called while the DUT sits in APPEND: records the colour it is about to store.
  task automatic model_append();
    logic [7:0] l;
    l = lfsr_after(cyc);
    model_seq.push_back(l[1:0]);
    $display("append: round %0d colour %0d", model_seq.size(), l[1:0]);
  endtask

  task automatic do_start();
    start = 1'b1; play_tick = 1'b1; clk1(); start = 1'b0; play_tick = 1'b0;
    model_seq.delete();
    chk("start_round0", 8'(round), 8'd0);
    chk("start_no_show", 8'(show_valid), 8'd0);
    chk("start_go_clr", 8'(game_over), 8'd0);
    chk("start_win_clr", 8'(win), 8'd0);
    model_append();
    clk1();
    chk("start_round1", 8'(round), 8'd1);
  endtask

  task automatic play_round(input bit drop);
    int n;
    int gap;
    n = model_seq.size();
    for (int i = 0; i < n; i++) begin
      gap = $urandom_range(drop ? 1 : 0, 3);
      for (int g = 0; g < gap; g++) begin
        if (drop && g == 0) begin btn_valid = 1'b1; btn_colour = 2'($urandom); end
        clk1(); btn_valid = 1'b0;
        chk("play_gap_no_show", 8'(show_valid), 8'd0);
        chk("play_no_cmp", 8'(cmp_enable), 8'd0);
      end
      play_tick = 1'b1; clk1(); play_tick = 1'b0;
      chk("show_valid", 8'(show_valid), 8'd1);
      chk("show_colour", 8'(show_colour), 8'(model_seq[i]));
      chk("awaiting_after_show", 8'(awaiting), 8'(i == n - 1));
      $display("show: idx %0d colour %0d", i, show_colour);
    end
  endtask

  task automatic press(input bit correct, input int idx, input bit drop);
    logic [1:0] c;
    int d;
    c = correct ? model_seq[idx] : model_seq[idx] ^ 2'($urandom_range(1, 3));
    d = $urandom_range(drop ? 1 : 0, 2);
    btn_valid = 1'b1; btn_colour = c; clk1(); btn_valid = 1'b0;
    chk("issue_cmp_en", 8'(cmp_enable), 8'd1);
    chk("issue_expected", 8'(expected), 8'(model_seq[idx]));
    chk("issue_player", 8'(player_colour), 8'(c));
    chk("issue_not_await", 8'(awaiting), 8'd0);
    clk1();
    chk("check_cmp_off", 8'(cmp_enable), 8'd0);
    for (int k = 0; k < d; k++) begin
      cmp_result = 2'b00;
      if (drop) begin btn_valid = 1'b1; btn_colour = c; end
      clk1(); btn_valid = 1'b0;
      chk("check_hold_no_cmp", 8'(cmp_enable), 8'd0);
      chk("check_hold_no_await", 8'(awaiting), 8'd0);
    end
    cmp_result = correct ? 2'b01 : 2'b10;
    clk1(); cmp_result = 2'b00;
    $display("press: idx %0d colour %0d correct %0d", idx, c, correct);
  endtask

  task automatic do_round(input bit drop);
    int n;
    n = model_seq.size();
    play_round(drop);
    for (int i = 0; i < n; i++) begin
      press(1'b1, i, drop);
      if (i < n - 1) chk("await_next_press", 8'(awaiting), 8'd1);
    end
    if (n < MAX_LEN) begin
      chk("append_round_hold", 8'(round), 8'(n));
      model_append();
      clk1();
      chk("round_grew", 8'(round), 8'(n + 1));
    end else begin
      chk("win_flag", 8'(win), 8'd1);
      chk("win_round", 8'(round), 8'(MAX_LEN));
    end
  endtask

  initial begin
    resetn = 1'b0;
    repeat (3) clk1();
    chk("rst_round", 8'(round), 8'd0);
    chk("rst_cmp", 8'(cmp_enable), 8'd0);
    chk("rst_show", 8'(show_valid), 8'd0);
    chk("rst_await", 8'(awaiting), 8'd0);
    chk("rst_go", 8'(game_over), 8'd0);
    chk("rst_win", 8'(win), 8'd0);
    resetn = 1'b1;
    repeat ($urandom_range(1, 9)) clk1();

    // Game 1: two good rounds, then a wrong second press in round 3.
    do_start();
    do_round(1'b0);
    do_round(1'b1);
    play_round(1'b0);
    press(1'b1, 0, 1'b0);
    chk("await_r3", 8'(awaiting), 8'd1);
    press(1'b0, 1, 1'b0);
    chk("lose_flag", 8'(game_over), 8'd1);
    chk("lose_no_await", 8'(awaiting), 8'd0);
    for (int k = 0; k < 4; k++) begin
      btn_valid = 1'b1; play_tick = 1'b1; btn_colour = 2'($urandom);
      clk1();
      btn_valid = 1'b0; play_tick = 1'b0;
      chk("lose_no_cmp", 8'(cmp_enable), 8'd0);
      chk("lose_no_show", 8'(show_valid), 8'd0);
      chk("lose_sticky", 8'(game_over), 8'd1);
      chk("lose_round", 8'(round), 8'd3);
    end

    // Game 2: all correct up to MAX_LEN.
    do_start();
    for (int r = 0; r < MAX_LEN; r++) do_round(1'($urandom));
    for (int k = 0; k < 3; k++) begin
      play_tick = 1'b1; btn_valid = 1'b1;
      clk1();
      play_tick = 1'b0; btn_valid = 1'b0;
      chk("win_sticky", 8'(win), 8'd1);
      chk("win_no_append", 8'(round), 8'(MAX_LEN));
      chk("win_no_show", 8'(show_valid), 8'd0);
    end

    // Game 3: restart while CHECK waits for a verdict.
    do_start();
    play_round(1'b0);
    btn_valid = 1'b1; btn_colour = model_seq[0]; clk1(); btn_valid = 1'b0;
    clk1();
    chk("pre_restart_check", 8'(cmp_enable), 8'd0);
    do_start();
    play_round(1'b0);
    btn_valid = 1'b1; btn_colour = model_seq[0]; clk1(); btn_valid = 1'b0;
    chk("issue_before_reset", 8'(cmp_enable), 8'd1);
    resetn = 1'b0;
    #1;
    chk("midreset_cmp", 8'(cmp_enable), 8'd0);
    chk("midreset_round", 8'(round), 8'd0);
    chk("midreset_await", 8'(awaiting), 8'd0);
    repeat (2) clk1();
    resetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      play_tick = 1'b1; btn_valid = 1'b1; cmp_result = 2'b01;
      clk1();
      chk("idle_no_show", 8'(show_valid), 8'd0);
      chk("idle_no_cmp", 8'(cmp_enable), 8'd0);
      chk("idle_round", 8'(round), 8'd0);
    end
    play_tick = 1'b0; btn_valid = 1'b0; cmp_result = 2'b00;

    // Fresh game after reset: first colour follows the LFSR from SEED again.
    do_start();
    do_round(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/simon_sequence_ctrl.md
Name: simon_sequence_ctrl

Overview:
- Game sequencer for the Simon datapath. It sits directly upstream of the colour comparator.
- Grows a pseudo-random 2-bit colour sequence by one entry per round and plays it back paced by an external tick.
- Collects player button presses and presents each one to the comparator, alongside the expected colour.
- Consumes the comparator's 2-bit verdict to advance the round, end in a loss, or declare a win.

Parameters:
- MAX_LEN, 16, maximum sequence length; reaching it with all matches is a win.
- LEN_W, 5, width of the length/index counters; must hold MAX_LEN.
- SEED, 8'hA5, LFSR reset value; must be non-zero.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a new game from any state.
- play_tick  in  1  playback pacing pulse; one colour shown per tick.
- btn_valid  in  1  one-cycle pulse; player pressed a button.
- btn_colour  in  2  colour of the pressed button.
- cmp_result  in  2  comparator verdict: 01 match, 10 mismatch, 00 none.
- player_colour  out  2  to comparator in.
- expected  out  2  to comparator compare.
- cmp_enable  out  1  to comparator enable; one-cycle pulse.
- show_valid  out  1  one-cycle pulse; show_colour is to be displayed.
- show_colour  out  2  colour being played back.
- awaiting_input  out  1  high while in WAIT_IN.
- round  out  LEN_W  current sequence length.
- game_over  out  1  sticky loss flag.
- win  out  1  sticky win flag.

Behaviour:
- Reset:
  - resetn low asynchronously forces state IDLE and clears all outputs, round, and indices to 0.
  - The LFSR loads SEED.
  - The sequence memory is not cleared.
  - Reset asserted mid-game aborts immediately with no further cmp_enable or show_valid.
- All outputs are registered.
- LFSR:
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1.
  - Shifts every clock from reset.
  - The new colour is lfsr[1:0] sampled in APPEND.
- States: IDLE, APPEND, PLAY, WAIT_IN, ISSUE, CHECK, LOSE, WIN.
- start: overrides every state.
  - Next state APPEND; round, play_idx and in_idx cleared; game_over and win cleared.
- IDLE: waits for start.
- APPEND: one cycle.
  - mem[round] <= lfsr[1:0]; round <= round+1.
  - -> PLAY with play_idx=0.
- PLAY: on play_tick:
  - show_colour <= mem[play_idx], show_valid <= 1 for one cycle.
  - If play_idx==round-1 -> WAIT_IN with in_idx=0; else play_idx++.
  - Cycles without play_tick hold state.
- WAIT_IN: awaiting_input=1. On btn_valid:
  - player_colour <= btn_colour, expected <= mem[in_idx], cmp_enable <= 1.
  - -> ISSUE.
- ISSUE: cmp_enable is high for exactly this one cycle.
  - The comparator registers its verdict at the end of it.
  - -> CHECK.
- CHECK: samples cmp_result.
  - 01 with in_idx<round-1: in_idx++ -> WAIT_IN.
  - 01 with in_idx==round-1 and round<MAX_LEN: -> APPEND.
  - 01 with in_idx==round-1 and round==MAX_LEN: -> WIN.
  - 10: -> LOSE.
  - 00: hold in CHECK.
- Timing: btn_valid sampled at edge E0 -> cmp_enable high E0..E1 -> verdict valid after E1 -> acted on at E2.
- player_colour and expected hold their values until the next issue.
- LOSE / WIN: game_over=1 or win=1, held until start or reset. round holds the final length.
- Ignored inputs:
  - btn_valid outside WAIT_IN is dropped, not queued; this includes ISSUE, CHECK and PLAY.
  - play_tick outside PLAY is dropped.
- Simultaneous events:
  - start and btn_valid in the same cycle: start wins.
  - play_tick and start in the same cycle: start wins, no show_valid.
- Widths:
  - round and indices are LEN_W bits, never exceeding MAX_LEN.
  - mem is MAX_LEN x 2 bits, indexed by the low bits of the counters.

Test Plan:
- Reset and first round:
  - Stimulus: reset, then start.
  - Required: round=1 two cycles later; first play_tick gives show_valid=1 with show_colour = SEED-derived lfsr[1:0] (checked against a reference LFSR model); then awaiting_input=1.
- Correct input:
  - Stimulus: replay round 1 by pressing show_colour, with a comparator model returning 01.
  - Required: cmp_enable pulses one cycle later, expected equals the shown colour, APPEND follows, round=2, and two show_valid pulses occur before the next WAIT_IN.
- Mismatch:
  - Stimulus: in round 3, second press wrong; model returns 10.
  - Required: game_over=1 at E2 and stays high; further btn_valid and play_tick produce no cmp_enable or show_valid.
- Win:
  - Stimulus: MAX_LEN=4, all presses correct.
  - Required: after the 4th verdict of round 4, win=1, round=4, no APPEND.
- Dropped presses:
  - Stimulus: btn_valid during PLAY and during CHECK.
  - Required: no cmp_enable; in_idx unchanged.
- Restart and reset mid-game:
  - Stimulus: start asserted in CHECK.
  - Required: round=1, game_over=0, new APPEND.
  - Stimulus: resetn low during ISSUE.
  - Required: cmp_enable=0 immediately and state IDLE.
